// File: rtl/hood_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_sequencer
// Description : Sequencing controller for the range-hood fan datapath. Turns
//               debounced front-panel buttons and a 1 Hz tick into the
//               mode_state code for the fan/timer block. Enforces menu entry,
//               the one-shot hurricane timeout and the forced level-2 purge
//               when hurricane is aborted from the menu.
//
// Parameters  : HURRICANE_SEC - hurricane run length in seconds (1..99)
//               PURGE_SEC     - level-2 purge length in seconds (1..99)
//
// Ports       : clk              - system clock
//               rst              - synchronous reset, active-high
//               tick_1s          - one-clk pulse per second
//               power_on         - level; low forces OFF
//               menu_btn         - debounced level, edge-detected here
//               mode1_btn        - debounced level, edge-detected here
//               mode2_btn        - debounced level, edge-detected here
//               mode3_btn        - debounced level, edge-detected here
//               mode_state       - 0 off, 1 level 1, 2 level 2, 3 hurricane
//               menu_active      - high while in MENU
//               hurricane_used   - hurricane consumed this power cycle
//               countdown_active - high in HURR or PURGE
//               countdown_sec    - remaining seconds in HURR/PURGE, else 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_sequencer #(
    parameter int HURRICANE_SEC = 60,
    parameter int PURGE_SEC     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       power_on,
    input  logic       menu_btn,
    input  logic       mode1_btn,
    input  logic       mode2_btn,
    input  logic       mode3_btn,
    output logic [2:0] mode_state,
    output logic       menu_active,
    output logic       hurricane_used,
    output logic       countdown_active,
    output logic [6:0] countdown_sec
);

    localparam logic [6:0] c_hurr_load  = 7'(HURRICANE_SEC);
    localparam logic [6:0] c_purge_load = 7'(PURGE_SEC);

    // Button vector bit positions
    localparam int c_b_mode1 = 0;
    localparam int c_b_mode2 = 1;
    localparam int c_b_mode3 = 2;
    localparam int c_b_menu  = 3;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_MENU    = 3'd2,
        ST_L1      = 3'd3,
        ST_L2      = 3'd4,
        ST_HURR    = 3'd5,
        ST_PURGE   = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_count;
    logic [6:0] w_count_nxt;
    logic       r_hurr_used;
    logic       w_hurr_used_nxt;

    logic [3:0] w_btn;
    logic [3:0] r_btn_q;
    logic [3:0] w_press;

    // One-hot winner after priority resolution
    logic       w_win_menu;
    logic       w_win_mode3;
    logic       w_win_mode2;
    logic       w_win_mode1;

    logic [2:0] w_mode_state_nxt;
    logic       w_menu_active_nxt;
    logic       w_cd_active_nxt;

    logic [2:0] r_mode_state;
    logic       r_menu_active;
    logic       r_cd_active;
    logic [6:0] r_cd_sec;

    // ------------------------------------------------------------------
    // Edge detection. The history register resets to all-ones so a button
    // already held when reset releases is not seen as a fresh press.
    // ------------------------------------------------------------------
    assign w_btn   = {menu_btn, mode3_btn, mode2_btn, mode1_btn};
    assign w_press = w_btn & ~r_btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 4'b1111;
        end else begin
            r_btn_q <= w_btn;
        end
    end

    // Only the highest-priority press in a cycle is acted on:
    // menu > mode3 > mode2 > mode1.
    assign w_win_menu  = w_press[c_b_menu];
    assign w_win_mode3 = w_press[c_b_mode3] & ~w_press[c_b_menu];
    assign w_win_mode2 = w_press[c_b_mode2] & ~w_press[c_b_menu]
                       & ~w_press[c_b_mode3];
    assign w_win_mode1 = w_press[c_b_mode1] & ~w_press[c_b_menu]
                       & ~w_press[c_b_mode3] & ~w_press[c_b_mode2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OFF;
            r_count     <= 7'd0;
            r_hurr_used <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_hurr_used <= w_hurr_used_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_hurr_used_nxt = r_hurr_used;

        if (!power_on) begin
            // Power loss outranks every button and tick and re-arms hurricane.
            w_state_nxt     = ST_OFF;
            w_count_nxt     = 7'd0;
            w_hurr_used_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_STANDBY;
                end

                ST_STANDBY: begin
                    if (w_win_menu) begin
                        w_state_nxt = ST_MENU;
                    end
                end

                ST_MENU: begin
                    if (w_win_menu) begin
                        w_state_nxt = ST_STANDBY;
                    end else if (w_win_mode3) begin
                        // A refused hurricane request still consumes the
                        // cycle's press; lower-priority presses are dropped.
                        if (!r_hurr_used) begin
                            w_state_nxt     = ST_HURR;
                            w_count_nxt     = c_hurr_load;
                            w_hurr_used_nxt = 1'b1;
                        end
                    end else if (w_win_mode2) begin
                        w_state_nxt = ST_L2;
                    end else if (w_win_mode1) begin
                        w_state_nxt = ST_L1;
                    end
                end

                ST_L1, ST_L2: begin
                    // mode3 wins priority but is not actionable here.
                    if (w_win_menu) begin
                        w_state_nxt = ST_STANDBY;
                    end else if (w_win_mode2) begin
                        w_state_nxt = ST_L2;
                    end else if (w_win_mode1) begin
                        w_state_nxt = ST_L1;
                    end
                end

                ST_HURR: begin
                    // Menu abort beats a coincident tick, even at count 1.
                    if (w_win_menu) begin
                        w_state_nxt = ST_PURGE;
                        w_count_nxt = c_purge_load;
                    end else if (tick_1s) begin
                        if (r_count <= 7'd1) begin
                            w_state_nxt = ST_L2;
                            w_count_nxt = 7'd0;
                        end else begin
                            w_count_nxt = r_count - 7'd1;
                        end
                    end
                end

                ST_PURGE: begin
                    if (tick_1s) begin
                        if (r_count <= 7'd1) begin
                            w_state_nxt = ST_STANDBY;
                            w_count_nxt = 7'd0;
                        end else begin
                            w_count_nxt = r_count - 7'd1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_OFF;
                    w_count_nxt = 7'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, registered below so every output
    // is a flop and tracks the state register on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_mode_state_nxt  = 3'd0;
        w_menu_active_nxt = 1'b0;
        w_cd_active_nxt   = 1'b0;

        case (w_state_nxt)
            ST_L1:    w_mode_state_nxt = 3'd1;
            ST_L2:    w_mode_state_nxt = 3'd2;
            ST_PURGE: begin
                w_mode_state_nxt = 3'd2;
                w_cd_active_nxt  = 1'b1;
            end
            ST_HURR:  begin
                w_mode_state_nxt = 3'd3;
                w_cd_active_nxt  = 1'b1;
            end
            ST_MENU:  w_menu_active_nxt = 1'b1;
            default:  w_mode_state_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_state  <= 3'd0;
            r_menu_active <= 1'b0;
            r_cd_active   <= 1'b0;
            r_cd_sec      <= 7'd0;
        end else begin
            r_mode_state  <= w_mode_state_nxt;
            r_menu_active <= w_menu_active_nxt;
            r_cd_active   <= w_cd_active_nxt;
            // Count is only meaningful while a countdown is running.
            r_cd_sec      <= w_cd_active_nxt ? w_count_nxt : 7'd0;
        end
    end

    assign mode_state       = r_mode_state;
    assign menu_active      = r_menu_active;
    assign hurricane_used   = r_hurr_used;
    assign countdown_active = r_cd_active;
    assign countdown_sec    = r_cd_sec;

endmodule
`default_nettype wire

// File: tb/tb_hood_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hood_mode_sequencer
// Description : Self-checking bench for hood_mode_sequencer. A table of
//               single-cycle vectors covers entry, level switching, the
//               hurricane timeout, refusals and power-off; hand sequences
//               cover purge, coincident tick/menu, power cycling and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hood_mode_sequencer;

    localparam int HURRICANE_SEC = 5;
    localparam int PURGE_SEC     = 3;

    logic       clk;
    logic       rst;
    logic       tick_1s;
    logic       power_on;
    logic       menu_btn;
    logic       mode1_btn;
    logic       mode2_btn;
    logic       mode3_btn;
    logic [2:0] mode_state;
    logic       menu_active;
    logic       hurricane_used;
    logic       countdown_active;
    logic [6:0] countdown_sec;

    int n_total;
    int n_pass;

    hood_mode_sequencer #(
        .HURRICANE_SEC (HURRICANE_SEC),
        .PURGE_SEC     (PURGE_SEC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1s          (tick_1s),
        .power_on         (power_on),
        .menu_btn         (menu_btn),
        .mode1_btn        (mode1_btn),
        .mode2_btn        (mode2_btn),
        .mode3_btn        (mode3_btn),
        .mode_state       (mode_state),
        .menu_active      (menu_active),
        .hurricane_used   (hurricane_used),
        .countdown_active (countdown_active),
        .countdown_sec    (countdown_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pw;
        logic       mn;
        logic       m1;
        logic       m2;
        logic       m3;
        logic       tk;
        logic [2:0] ms;
        logic       ma;
        logic       hu;
        logic       ca;
        logic [6:0] cs;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] ms, input logic ma,
                           input logic hu, input logic ca, input logic [6:0] cs);
        chk({name, ".mode_state"}, int'(mode_state), int'(ms));
        chk({name, ".menu_active"}, int'(menu_active), int'(ma));
        chk({name, ".hurricane_used"}, int'(hurricane_used), int'(hu));
        chk({name, ".countdown_active"}, int'(countdown_active), int'(ca));
        chk({name, ".countdown_sec"}, int'(countdown_sec), int'(cs));
    endtask

    // Drive one clock cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic pw, input logic mn, input logic m1,
                       input logic m2, input logic m3, input logic tk);
        @(negedge clk);
        power_on  = pw;
        menu_btn  = mn;
        mode1_btn = m1;
        mode2_btn = m2;
        mode3_btn = m3;
        tick_1s   = tk;
        @(posedge clk);
        #1;
    endtask

    // Nine idle cycles then one tick cycle: tick_1s every 10 clk.
    task automatic one_tick();
        repeat (9) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
    endtask

    task automatic add(input logic pw, input logic mn, input logic m1, input logic m2,
                       input logic m3, input logic tk, input logic [2:0] ms,
                       input logic ma, input logic hu, input logic ca,
                       input logic [6:0] cs);
        vec_t v;
        v.pw = pw; v.mn = mn; v.m1 = m1; v.m2 = m2; v.m3 = m3; v.tk = tk;
        v.ms = ms; v.ma = ma; v.hu = hu; v.ca = ca; v.cs = cs;
        vecs.push_back(v);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        tick_1s   = 1'b0;
        power_on  = 1'b0;
        menu_btn  = 1'b0;
        mode1_btn = 1'b0;
        mode2_btn = 1'b0;
        mode3_btn = 1'b0;

        //   pw mn m1 m2 m3 tk | ms ma hu ca cs
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // OFF -> STANDBY
        add(1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0);  // menu -> MENU
        add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0,   2, 0, 0, 0, 0);  // mode2 -> L2
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // mode1 -> L1
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);  // mode3 ignored in L1
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // menu -> STANDBY
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0);  // -> MENU
        add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,   3, 0, 1, 1, 5);  // -> HURR, load 5
        add(1, 0, 0, 0, 0, 0,   3, 0, 1, 1, 5);
        add(1, 0, 0, 0, 0, 1,   3, 0, 1, 1, 4);
        add(1, 0, 0, 0, 0, 1,   3, 0, 1, 1, 3);
        add(1, 0, 0, 0, 0, 1,   3, 0, 1, 1, 2);
        add(1, 0, 0, 0, 0, 1,   3, 0, 1, 1, 1);
        add(1, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0);  // timeout -> L2
        add(1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // -> STANDBY
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0);  // -> MENU
        add(1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0);  // second hurricane refused
        add(1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0,   0, 1, 1, 0, 0);  // mode3 wins over mode2, refused
        add(1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0);  // menu beats mode1 -> STANDBY
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // power off clears used
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // press ignored when off
        add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // OFF -> STANDBY only
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].pw, vecs[i].mn, vecs[i].m1, vecs[i].m2, vecs[i].m3, vecs[i].tk);
            chk_all($sformatf("vec%0d", i), vecs[i].ms, vecs[i].ma, vecs[i].hu,
                    vecs[i].ca, vecs[i].cs);
        end

        // Purge after menu abort at count 3, with ticks every 10 clk
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk_all("purge.hurr_entry", 3, 0, 1, 1, 5);
        cyc(1, 0, 0, 0, 0, 0);
        one_tick();
        chk("purge.cnt4", int'(countdown_sec), 4);
        one_tick();
        chk("purge.cnt3", int'(countdown_sec), 3);
        cyc(1, 1, 0, 0, 0, 0);
        chk_all("purge.entry", 2, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk_all("purge.mode1_ign", 2, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk_all("purge.mode3_ign", 2, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0);
        one_tick();
        chk("purge.cnt2", int'(countdown_sec), 2);
        one_tick();
        chk("purge.cnt1", int'(countdown_sec), 1);
        one_tick();
        chk_all("purge.done", 0, 0, 1, 0, 0);

        // Coincident events: tick on HURR entry, menu+tick at count 1
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1);
        chk_all("simul.entry_tick", 3, 0, 1, 1, 5);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (4) one_tick();
        chk_all("simul.cnt1", 3, 0, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk_all("simul.menu_tick", 2, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) one_tick();
        chk_all("simul.purge_done", 0, 0, 1, 0, 0);

        // Power drop mid-hurricane, then hurricane allowed again
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        one_tick();
        chk_all("pwr.hurr", 3, 0, 1, 1, 4);
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("pwr.drop", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk_all("pwr.rearm", 3, 0, 1, 1, 5);
        cyc(1, 0, 0, 0, 0, 0);

        // Reset mid-countdown with mode1 held through reset release
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 1, 0, 0, 0);
        chk_all("rst.mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 1, 0, 0, 0);
        chk_all("rst.standby", 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk_all("rst.held", 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk_all("rst.menu", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
